// File: rtl/uart_tx_mmio.sv
// Memory-mapped UART transmitter: TXDATA stores feed a byte FIFO that is serialised as 8N1 on txd.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1) and set STATUS[9].
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  output logic        sel,
  output logic [31:0] rdata,
  output logic        txd,
  output logic        irq_empty
);

  localparam int unsigned   PW          = $clog2(FIFO_DEPTH);
  localparam int unsigned   BW          = $clog2(CLKS_PER_BIT);
  localparam logic [4:0]    DEPTH5      = 5'(FIFO_DEPTH);
  localparam logic [BW-1:0] BMAX        = BW'(CLKS_PER_BIT - 1);
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic       PAR_FLAG = 1'b1;
`else
  localparam logic       PAR_FLAG = 1'b0;
`endif

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_overflow;
  logic [2:0]    r_state;
  logic [BW-1:0] r_bcnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_txd;
  logic          r_irq_empty;
  logic          r_parity;

  logic          w_hit_tx, w_hit_st, w_push, w_pop, w_bdone;
  logic [4:0]    w_count_d;
  logic [2:0]    w_state_d;
  logic [BW-1:0] w_bcnt_d;
  logic [2:0]    w_bit_idx_d;
  logic [7:0]    w_shift_d;
  logic [7:0]    w_head;
  logic          w_txd_d;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_unused = ^{wdata[31:8], wdata[7:4], wdata[2:0]};

  assign w_hit_tx = mem_write && (addr == BASE_ADDR);
  assign w_hit_st = mem_write && (addr == STATUS_ADDR);
  assign w_head   = r_mem[r_rd_ptr];
  assign w_bdone  = (r_bcnt == BMAX);

  // A same-edge pop frees a slot, so a push into a full FIFO is still accepted.
  assign w_push    = w_hit_tx && ((r_count != DEPTH5) || w_pop);
  assign w_count_d = r_count + 5'(w_push) - 5'(w_pop);

  always_comb begin
    w_state_d   = r_state;
    w_bcnt_d    = w_bdone ? '0 : r_bcnt + BW'(1);
    w_bit_idx_d = r_bit_idx;
    w_shift_d   = r_shift;
    w_txd_d     = r_txd;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_bcnt_d = '0;
        w_txd_d  = 1'b1;
        if (r_count != 5'd0) begin
          w_pop     = 1'b1;
          w_shift_d = w_head;
          w_state_d = S_START;
          w_txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (w_bdone) begin
          w_state_d   = S_DATA;
          w_bit_idx_d = 3'd0;
          w_txd_d     = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bdone) begin
          if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_d = S_PARITY;
            w_txd_d   = r_parity;
`else
            w_state_d = S_STOP;
            w_txd_d   = 1'b1;
`endif
          end else begin
            w_shift_d   = {1'b0, r_shift[7:1]};
            w_bit_idx_d = r_bit_idx + 3'd1;
            w_txd_d     = r_shift[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bdone) begin
          w_state_d = S_STOP;
          w_txd_d   = 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (w_bdone) begin
          w_state_d = S_IDLE;
          w_txd_d   = 1'b1;
        end
      end
      default: begin
        w_state_d = S_IDLE;
        w_bcnt_d  = '0;
        w_txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= 5'd0;
      r_overflow  <= 1'b0;
      r_state     <= S_IDLE;
      r_bcnt      <= '0;
      r_bit_idx   <= 3'd0;
      r_shift     <= 8'd0;
      r_txd       <= 1'b1;
      r_irq_empty <= 1'b1;
      r_parity    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
        r_parity <= ^w_head;
      end
      r_count   <= w_count_d;
      if (w_hit_st && wdata[3]) begin
        r_overflow <= 1'b0;
      end else if (w_hit_tx && !w_push) begin
        r_overflow <= 1'b1;
      end
      r_state     <= w_state_d;
      r_bcnt      <= w_bcnt_d;
      r_bit_idx   <= w_bit_idx_d;
      r_shift     <= w_shift_d;
      r_txd       <= w_txd_d;
      r_irq_empty <= (w_count_d == 5'd0) && (w_state_d == S_IDLE);
    end
  end

  assign w_status = {22'd0, PAR_FLAG, r_count, r_overflow, (r_count == 5'd0),
                     (r_count == DEPTH5), (r_state != S_IDLE)};

  assign sel       = (addr == BASE_ADDR) || (addr == STATUS_ADDR);
  assign rdata     = (addr == STATUS_ADDR) ? w_status : 32'd0;
  assign txd       = r_txd;
  assign irq_empty = r_irq_empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio: decode vector table plus directed serial-line sequences.
module tb_uart_tx_mmio;

  localparam int unsigned CPB  = 4;
  localparam logic [31:0] TXA  = 32'h1000;
  localparam logic [31:0] STA  = 32'h1004;
`ifdef UART_TX_PARITY_EN
  localparam logic [31:0] PBIT  = 32'h200;
  localparam int          FRAME = 11 * CPB;
`else
  localparam logic [31:0] PBIT  = 32'h0;
  localparam int          FRAME = 10 * CPB;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr, wdata, rdata;
  logic        mem_write, sel, txd, irq_empty;

  int n_checks = 0;
  int n_pass   = 0;

  uart_tx_mmio #(
    .BASE_ADDR   (TXA),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .mem_write(mem_write),
    .sel      (sel),
    .rdata    (rdata),
    .txd      (txd),
    .irq_empty(irq_empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1);
  end

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0; addr = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    mem_write = 1'b0; addr = STA;
    @(negedge clk);
    v = rdata;
  endtask

  // Waits for a start bit, then samples every cycle of one frame at the falling clock edge.
  task automatic get_frame(input int max_wait, output int waited, output logic [7:0] data,
                           output logic par, output logic ok);
    int b;
    waited = 0; data = 8'h00; par = 1'b0; ok = 1'b0;
    @(negedge clk);
    while (txd !== 1'b0 && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    if (txd !== 1'b0) begin
      waited = -1;
      return;
    end
    ok = 1'b1;
    for (int k = 0; k < FRAME; k++) begin
      if (k != 0) @(negedge clk);
      b = k / CPB;
      if (b == 0) begin
        if (txd !== 1'b0) ok = 1'b0;
      end else if (b <= 8) begin
        if (k % CPB == 0) data[b-1] = txd;
        else if (txd !== data[b-1]) ok = 1'b0;
      end else if (b == 9 && FRAME == 11 * CPB) begin
        if (k % CPB == 0) par = txd;
        else if (txd !== par) ok = 1'b0;
      end else if (txd !== 1'b1) ok = 1'b0;
    end
  endtask

  int          fw [6];
  logic [7:0]  fd [6];
  logic        fp [6];
  logic        fok [6];
  logic [7:0]  exp5 [5];

  initial begin
    logic [31:0] st;
    int          w;
    logic [7:0]  d;
    logic        p, ok, found;

    vecs[0] = '{1'b0, 32'h1000, 32'h0,         1'b1, 32'h0};
    vecs[1] = '{1'b0, 32'h1004, 32'h0,         1'b1, 32'h4 | PBIT};
    vecs[2] = '{1'b0, 32'h1008, 32'h0,         1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h0FFC, 32'h0,         1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h1002, 32'h0,         1'b0, 32'h0};
    vecs[5] = '{1'b1, 32'h1008, 32'hAB,        1'b0, 32'h0};
    vecs[6] = '{1'b1, 32'h0000, 32'h12,        1'b0, 32'h0};
    vecs[7] = '{1'b1, 32'h1004, 32'hFFFF_FFFF, 1'b1, 32'h4 | PBIT};
    vecs[8] = '{1'b0, 32'h2004, 32'h0,         1'b0, 32'h0};

    // Reset state
    reset = 1'b0; mem_write = 1'b0; addr = STA; wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'h1);
    check("rst_irq", 32'(irq_empty), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_status", rdata, 32'h4 | PBIT);
    check("post_rst_txd", 32'(txd), 32'h1);
    check("post_rst_irq", 32'(irq_empty), 32'h1);
    @(posedge clk); #1;

    // Address decode and side-effect-free writes
    foreach (vecs[i]) begin
      addr = vecs[i].a; wdata = vecs[i].d; mem_write = vecs[i].we;
      @(negedge clk);
      check($sformatf("vec%0d_sel", i), 32'(sel), 32'(vecs[i].exp_sel));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      @(posedge clk); #1;
      mem_write = 1'b0; addr = STA;
      @(negedge clk);
      check($sformatf("vec%0d_after", i), rdata | {31'd0, ~txd}, 32'h4 | PBIT);
      @(posedge clk); #1;
    end

    // Single byte A5
    bus_write(TXA, 32'hA5);
    addr = STA; #1;
    check("a5_status_queued", rdata, 32'h10 | PBIT);
    check("a5_irq_low", 32'(irq_empty), 32'h0);
    get_frame(10, w, d, p, ok);
    check("a5_wait", 32'(w), 32'd1);
    check("a5_data", 32'(d), 32'hA5);
    check("a5_framing", 32'(ok), 32'h1);
    check("a5_irq_in_stop", 32'(irq_empty), 32'h0);
    @(negedge clk);
    check("a5_irq_done", 32'(irq_empty), 32'h1);
    check("a5_idle_txd", 32'(txd), 32'h1);
    @(posedge clk); #1;

    // Back-to-back fill, overflow, overflow clear
    fork
      begin
        for (int i = 0; i < 5; i++) get_frame(10, fw[i], fd[i], fp[i], fok[i]);
        get_frame(60, fw[5], fd[5], fp[5], fok[5]);
      end
      begin
        for (int i = 1; i <= 5; i++) bus_write(TXA, 32'(i));
        read_status(st);
        check("fill_status", st, 32'h43 | PBIT);
        bus_write(TXA, 32'hEE);
        read_status(st);
        check("ovf_status", st, 32'h4B | PBIT);
        bus_write(STA, 32'h8);
        read_status(st);
        check("ovf_clear_status", st, 32'h43 | PBIT);
        check("fill_irq", 32'(irq_empty), 32'h0);
      end
    join
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b%0d_data", i), 32'(fd[i]), 32'(i + 1));
      check($sformatf("b2b%0d_framing", i), 32'(fok[i]), 32'h1);
      if (i > 0) check($sformatf("b2b%0d_gap", i), 32'(fw[i]), 32'd1);
    end
    check("dropped_byte_absent", 32'(fw[5]), 32'hFFFF_FFFF);
    read_status(st);
    check("b2b_end_status", st, 32'h4 | PBIT);
    check("b2b_end_irq", 32'(irq_empty), 32'h1);
    @(posedge clk); #1;

    // Push into a full FIFO on the pop edge
    bus_write(TXA, 32'h11);
    bus_write(TXA, 32'h22);
    bus_write(TXA, 32'h33);
    bus_write(TXA, 32'h44);
    bus_write(TXA, 32'h55);
    addr = STA;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      @(negedge clk);
      if (rdata[0] == 1'b0 && rdata[8:4] == 5'd4) found = 1'b1;
    end
    check("popedge_found", 32'(found), 32'h1);
    check("popedge_pre_status", rdata, 32'h42 | PBIT);
    addr = TXA; wdata = 32'hC3; mem_write = 1'b1;
    @(posedge clk); #1;
    mem_write = 1'b0; addr = STA; #1;
    check("popedge_status", rdata, 32'h43 | PBIT);
    exp5[0] = 8'h22; exp5[1] = 8'h33; exp5[2] = 8'h44; exp5[3] = 8'h55; exp5[4] = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      get_frame(10, w, d, p, ok);
      check($sformatf("popedge%0d_data", i), 32'(d), 32'(exp5[i]));
      check($sformatf("popedge%0d_gap", i), 32'(w), (i == 0) ? 32'd0 : 32'd1);
    end

    // Reset during bit 3
    bus_write(TXA, 32'hF0);
    bus_write(TXA, 32'h55);
    addr = STA;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (txd === 1'b0) found = 1'b1;
    end
    check("midrst_start_seen", 32'(found), 32'h1);
    repeat (17) @(negedge clk);
    check("midrst_bit3_low", 32'(txd), 32'h0);
    reset = 1'b0; #1;
    check("midrst_txd", 32'(txd), 32'h1);
    check("midrst_status", rdata, 32'h4 | PBIT);
    check("midrst_irq", 32'(irq_empty), 32'h1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    read_status(st);
    check("midrst_release_status", st, 32'h4 | PBIT);
    get_frame(60, w, d, p, ok);
    check("midrst_fifo_lost", 32'(w), 32'hFFFF_FFFF);
    @(posedge clk); #1;

    // Parity-sensitive bytes
    bus_write(TXA, 32'h07);
    get_frame(10, w, d, p, ok);
    check("b07_data", 32'(d), 32'h07);
    check("b07_framing", 32'(ok), 32'h1);
`ifdef UART_TX_PARITY_EN
    check("b07_parity", 32'(p), 32'(^8'h07));
`endif
    @(negedge clk);
    check("b07_irq_done", 32'(irq_empty), 32'h1);
    @(posedge clk); #1;
    bus_write(TXA, 32'h03);
    get_frame(10, w, d, p, ok);
    check("b03_data", 32'(d), 32'h03);
    check("b03_framing", 32'(ok), 32'h1);
`ifdef UART_TX_PARITY_EN
    check("b03_parity", 32'(p), 32'(^8'h03));
`endif
    @(negedge clk);
    check("b03_irq_done", 32'(irq_empty), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
